// File: rtl/sel_mux_rr.sv
// sel_mux_rr: registered N-input word multiplexer with valid/ready on every
// channel. A channel is chosen either directly by `control` (fixed mode) or
// by a round-robin scan starting after the last channel that transferred.
// The chosen word is captured into a single output register; that register
// only reloads when it is empty or being drained in the same cycle.
module sel_mux_rr #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        control,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  // Valid bits widened to the full select range so an out-of-range
  // `control` reads a zero instead of indexing past the port.
  localparam int PAD_W = 1 << SEL_W;

  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_src;
  logic [SEL_W-1:0] r_last;

  logic [PAD_W-1:0] w_valid_pad;
  logic             w_free;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [SEL_W-1:0] w_cand;
  logic [WIDTH-1:0] w_gnt_data;
  int               w_scan;

  // Output register can take a word when empty or drained this cycle.
  assign w_free = !r_out_valid || out_ready;

  // Zero-extend the valid vector to every encodable channel index.
  always_comb begin
    w_valid_pad             = '0;
    w_valid_pad[NUM_IN-1:0] = in_valid;
  end

  // Grant selection: direct index in fixed mode; in round-robin mode scan
  // last+1 .. last+NUM_IN. The scan runs from the far end back toward
  // last+1 so the nearest valid channel is the final (winning) assignment.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    w_cand    = '0;
    if (!mode) begin
      if (int'(control) < NUM_IN && w_valid_pad[control]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = control;
      end
    end else begin
      for (int k = NUM_IN; k >= 1; k--) begin
        w_scan = (int'(r_last) + k) % NUM_IN;
        w_cand = SEL_W'(w_scan);
        if (w_valid_pad[w_cand]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end
  end

  // Route the granted word and raise the single matching ready bit; ready
  // is suppressed during reset so no producer sees a phantom acceptance.
  always_comb begin
    w_gnt_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gnt_idx == SEL_W'(i)) begin
        w_gnt_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_free && w_gnt_vld && !reset;
      end
    end
  end

  // Output register and round-robin pointer; the pointer moves only on a
  // real transfer, whichever mode produced it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      r_last      <= SEL_W'(NUM_IN - 1);
    end else if (w_free) begin
      if (w_gnt_vld) begin
        r_out       <= w_gnt_data;
        r_out_src   <= w_gnt_idx;
        r_out_valid <= 1'b1;
        r_last      <= w_gnt_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_sel_mux_rr.sv
// Testbench for sel_mux_rr: default 3x16 instance plus a 5x32 instance.
module tb_sel_mux_rr;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [47:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [1:0]  control;
  logic        mode;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_src;

  logic [159:0] b_data;
  logic [4:0]   b_valid;
  logic [4:0]   b_ready;
  logic [2:0]   b_control;
  logic         b_mode;
  logic [31:0]  b_out;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [2:0]   b_out_src;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state for the 3-channel instance.
  logic [15:0] m_out;
  logic        m_vld;
  logic [1:0]  m_src;
  int          m_last;

  logic [15:0] words [3] = '{16'hA0A0, 16'hB1B1, 16'hC2C2};

  sel_mux_rr #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut_a (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .control(control), .mode(mode), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
  );

  sel_mux_rr #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) dut_b (
    .clock(clock), .reset(reset), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .control(b_control), .mode(b_mode), .out(b_out),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_src(b_out_src)
  );

  task automatic model_reset();
    m_out  = '0;
    m_vld  = 1'b0;
    m_src  = '0;
    m_last = 2;
  endtask

  // Channel that should win this cycle, or -1 when nothing is granted.
  function automatic int ref_grant();
    logic [3:0] v;
    v = {1'b0, in_valid};
    if (mode == 1'b0) begin
      if (v[control]) return int'(control);
      return -1;
    end
    for (int k = 1; k <= 3; k++) begin
      int j;
      j = (m_last + k) % 3;
      if (in_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [2:0] ref_ready();
    int g;
    g = ref_grant();
    if ((!m_vld || out_ready) && g >= 0) return 3'(1 << g);
    return 3'b000;
  endfunction

  // Advance one clock and apply the transfer rules to the reference state.
  task automatic tick();
    int          g;
    logic        free;
    logic [15:0] d;
    g    = ref_grant();
    free = !m_vld || out_ready;
    d    = '0;
    if (g >= 0) d = in_data[g*16 +: 16];
    @(posedge clock);
    #1;
    if (free) begin
      if (g >= 0) begin
        m_out  = d;
        m_src  = 2'(g);
        m_vld  = 1'b1;
        m_last = g;
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 3'b000) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 000", in_ready);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (out !== 16'h0 || out_valid !== 1'b0 || out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got out=%h vld=%b src=%0d expected 0/0/0", out, out_valid, out_src);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_fixed();
    in_data   = {words[2], words[1], words[0]};
    in_valid  = 3'b111;
    out_ready = 1'b1;
    mode      = 1'b0;
    for (int c = 0; c < 3; c++) begin
      control = 2'(c);
      for (int n = 0; n < 3; n++) begin
        #1;
        n_checks++;
        if (in_ready !== ref_ready()) begin
          n_fail++; $display("FAIL fixed_ready: got %b expected %b", in_ready, ref_ready());
        end
        tick();
        n_checks++;
        if (out !== words[c] || out_src !== 2'(c) || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL fixed_out: got %h src %0d vld %b expected %h src %0d vld 1", out, out_src, out_valid, words[c], c);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    control = 2'd3;
    #1;
    n_checks++;
    if (in_ready !== 3'b000) begin
      n_fail++; $display("FAIL oor_ready: got %b expected 000", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || m_vld !== 1'b0) begin
      n_fail++; $display("FAIL oor_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (out !== words[2] || out_src !== 2'd2) begin
      n_fail++; $display("FAIL oor_stale: got %h src %0d expected %h src 2", out, out_src, words[2]);
    end
  endtask

  task automatic test_rr_fair();
    int seq_all [6] = '{0, 1, 2, 0, 1, 2};
    int seq_02  [4] = '{0, 2, 0, 2};
    do_reset();
    mode      = 1'b1;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    in_data   = {words[2], words[1], words[0]};
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (out_src !== 2'(seq_all[i]) || out !== words[seq_all[i]] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL rr_all[%0d]: got src %0d out %h expected src %0d", i, out_src, out, seq_all[i]);
      end
    end
    in_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_src !== 2'(seq_02[i]) || out !== m_out) begin
        n_fail++; $display("FAIL rr_02[%0d]: got src %0d expected %0d", i, out_src, seq_02[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    mode      = 1'b0;
    control   = 2'd1;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    in_data   = {words[2], words[1], words[0]};
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 48'({$urandom(), $urandom()});
      #1;
      n_checks++;
      if (in_ready !== 3'b000) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 000", i, in_ready);
      end
      tick();
      n_checks++;
      if (out !== words[1] || out_valid !== 1'b1 || out_src !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %h vld %b expected %h vld 1", i, out, out_valid, words[1]);
      end
    end
    in_data   = {words[2], words[1], words[0]};
    control   = 2'd2;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 3'b100) begin
      n_fail++; $display("FAIL bp_release_ready: got %b expected 100", in_ready);
    end
    tick();
    n_checks++;
    if (out !== words[2] || out_src !== 2'd2 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_out: got %h src %0d expected %h src 2", out, out_src, words[2]);
    end
  endtask

  task automatic test_async_reset();
    mode      = 1'b1;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out !== 16'h0 || out_valid !== 1'b0 || out_src !== 2'd0 || in_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got out %h vld %b src %0d rdy %b expected 0/0/0/000", out, out_valid, out_src, in_ready);
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    n_checks++;
    if (out_src !== 2'd0 || out_valid !== 1'b1 || out !== words[0]) begin
      n_fail++; $display("FAIL async_restart: got src %0d vld %b expected src 0 vld 1", out_src, out_valid);
    end
  endtask

  task automatic test_sweep();
    in_valid = 3'b000;
    for (int i = 0; i < 5; i++) b_data[i*32 +: 32] = $urandom();
    do_reset();
    b_mode      = 1'b1;
    b_valid     = 5'h1f;
    b_out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      n_checks++;
      if (b_out_src !== 3'(k % 5) || b_out !== b_data[(k % 5)*32 +: 32] || b_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep[%0d]: got src %0d out %h expected src %0d out %h", k, b_out_src, b_out, k % 5, b_data[(k % 5)*32 +: 32]);
      end
    end
    b_valid = 5'h00;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_data   = 48'({$urandom(), $urandom()});
      in_valid  = 3'($urandom());
      control   = 2'($urandom_range(0, 3));
      mode      = 1'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (in_ready !== ref_ready()) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, in_ready, ref_ready());
      end
      tick();
      n_checks++;
      if (out !== m_out || out_valid !== m_vld || out_src !== m_src) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got %h/%b/%0d expected %h/%b/%0d", n, out, out_valid, out_src, m_out, m_vld, m_src);
      end
    end
  endtask

  initial begin
    in_data     = '0;
    in_valid    = '0;
    control     = '0;
    mode        = 1'b0;
    out_ready   = 1'b1;
    b_data      = '0;
    b_valid     = '0;
    b_control   = '0;
    b_mode      = 1'b0;
    b_out_ready = 1'b1;
    model_reset();
    test_reset();
    test_fixed();
    test_out_of_range();
    test_rr_fair();
    test_backpressure();
    test_async_reset();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
